// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks RF addresses FIRST_REG..LAST_REG and streams each
// 32-bit value as 8 ASCII hex chars (MSB nibble first) plus TERM_CHAR on a valid/ready byte port.
module rf_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31,
  parameter logic [7:0]  TERM_CHAR = 8'h0A,
  parameter bit          UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready
);

  localparam int         NIBS       = 8;
  localparam logic [4:0] FIRST_IDX  = FIRST_REG[4:0];
  localparam logic [4:0] LAST_IDX   = LAST_REG[4:0];
  localparam logic [7:0] ALPHA_BASE = UPPERCASE ? 8'h41 : 8'h61;
  localparam logic [3:0] TERM_NIB   = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] shadow_q, shadow_d;
  logic [3:0]  nib_q, nib_d;

  // All eight hex chars of the captured value, indexed by nibble position (7 = MSB).
  logic [NIBS-1:0][7:0] hex_c;
  for (genvar g = 0; g < NIBS; g++) begin : g_hex
    logic [3:0] n;
    assign n        = shadow_q[4*g +: 4];
    assign hex_c[g] = (n < 4'd10) ? (8'h30 + {4'h0, n})
                                  : (ALPHA_BASE + {4'h0, n} - 8'd10);
  end

  logic [2:0] hex_sel;
  logic [7:0] cur_char;
  logic       hs;

  assign hex_sel  = 3'd7 - nib_q[2:0];
  assign cur_char = (nib_q == TERM_NIB) ? TERM_CHAR : hex_c[hex_sel];
  assign hs       = char_valid & char_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      shadow_q <= '0;
      nib_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
      nib_q    <= nib_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    shadow_d = shadow_q;
    nib_d    = nib_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start && !abort) begin
          state_d = S_FETCH;
          idx_d   = FIRST_IDX;
          addr_d  = FIRST_IDX;
        end
        S_FETCH: begin
          shadow_d = rf_data;
          nib_d    = '0;
          state_d  = S_EMIT;
        end
        S_EMIT: if (hs) begin
          if (nib_q != TERM_NIB) begin
            nib_d = nib_q + 4'd1;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            addr_d  = idx_q + 5'd1;
            state_d = S_FETCH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
    char_valid = (state_q == S_EMIT);
    char_out   = char_valid ? cur_char : 8'h00;
    rf_addr    = addr_q;
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Randomized bench for rf_dump_reader: byte streams are checked against strings formatted
// directly from register values; a second instance covers a single-register lowercase dump.
module tb_rf_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, abort_a, ready_a, busy_a, done_a, valid_a;
  logic [4:0]  addr_a;
  logic [31:0] rdata_a;
  logic [7:0]  char_a;
  logic        start_b, abort_b, ready_b, busy_b, done_b, valid_b;
  logic [4:0]  addr_b;
  logic [31:0] rdata_b;
  logic [7:0]  char_b;

  logic [31:0] rf   [32];
  logic [31:0] snap [32];

  assign rdata_a = (addr_a == 5'd0) ? 32'd0 : rf[addr_a];
  assign rdata_b = (addr_b == 5'd0) ? 32'd0 : rf[addr_b];

  rf_dump_reader u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
    .rf_addr(addr_a), .rf_data(rdata_a), .char_out(char_a), .char_valid(valid_a),
    .char_ready(ready_a));

  rf_dump_reader #(.FIRST_REG(3), .LAST_REG(3), .TERM_CHAR(8'h0A), .UPPERCASE(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
    .rf_addr(addr_b), .rf_data(rdata_b), .char_out(char_b), .char_valid(valid_b),
    .char_ready(ready_b));

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference stream: each register formatted as 8 hex digits, then the terminator.
  function automatic void build_exp(input int first, input int last, input bit upper,
                                    input logic [7:0] term);
    exp_q.delete();
    for (int r = first; r <= last; r++) begin
      string s;
      s = $sformatf("%08h", (r == 0) ? 32'd0 : snap[r]);
      if (upper) s = s.toupper();
      for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
      exp_q.push_back(term);
    end
  endfunction

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_char%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk); #1;
    chk({tag, "_busy"}, 64'(busy_a), 64'd0);
    chk({tag, "_valid"}, 64'(valid_a), 64'd0);
  endtask

  // Runs one dump; cycle c counts negedges after the edge that samples start.
  task automatic run_dump(input bit use_b, input int rdy_pct, input int wr_cyc,
                          input int abort_cyc, input int rst_cyc, input bit rand_start,
                          output int done_cyc);
    logic       v, dn, bs, prev_stall;
    logic [7:0] ch, prev_ch;
    logic [4:0] ad;
    done_cyc   = -1;
    prev_stall = 1'b0;
    prev_ch    = 8'h00;
    got_q.delete();
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = use_b && rand_start && ($urandom_range(1) == 1);
      ready_a = !use_b && ($urandom_range(99) < rdy_pct);
      ready_b = use_b && ($urandom_range(99) < rdy_pct);
      abort_a = !use_b && (c == abort_cyc);
      if (wr_cyc > 0 && c == wr_cyc)     rf[2] = 32'h0000FFFF;
      if (wr_cyc > 0 && c == wr_cyc + 1) rf[2] = 32'hA5A5A5A5;
      #1;
      v  = use_b ? valid_b : valid_a;
      ch = use_b ? char_b  : char_a;
      dn = use_b ? done_b  : done_a;
      if (prev_stall) chk("stall_stable", {55'd0, v, ch}, {55'd0, 1'b1, prev_ch});
      if (c == abort_cyc) begin
        chk("abort_valid", 64'(valid_a), 64'd1);
        chk("abort_char", 64'(char_a), 64'(exp_q[48]));
        chk("abort_prefix_len", 64'(got_q.size()), 64'd48);
        @(negedge clk);
        abort_a = 1'b0; ready_a = 1'b0; #1;
        chk("abort_next_valid", 64'(valid_a), 64'd0);
        chk("abort_next_busy", 64'(busy_a), 64'd0);
        chk("abort_next_done", 64'(done_a), 64'd0);
        chk("abort_next_addr", 64'(addr_a), 64'd0);
        return;
      end
      if (c == rst_cyc) begin
        chk("prerst_valid", 64'(valid_a), 64'd1);
        reset = 1'b0; #1;
        chk("rst_mid_valid", 64'(valid_a), 64'd0);
        chk("rst_mid_char", 64'(char_a), 64'd0);
        chk("rst_mid_busy", 64'(busy_a), 64'd0);
        chk("rst_mid_done", 64'(done_a), 64'd0);
        chk("rst_mid_addr", 64'(addr_a), 64'd0);
        @(negedge clk);
        reset = 1'b1; ready_a = 1'b0;
        return;
      end
      if (v && (use_b ? ready_b : ready_a)) got_q.push_back(ch);
      prev_stall = v && !(use_b ? ready_b : ready_a);
      prev_ch    = ch;
      if (dn) begin
        done_cyc = c;
        break;
      end
    end
    if (done_cyc < 0) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0; #1;
    bs = use_b ? busy_b : busy_a;
    dn = use_b ? done_b : done_a;
    ad = use_b ? addr_b : addr_a;
    chk("post_done_busy", 64'(bs), 64'd0);
    chk("post_done_done", 64'(dn), 64'd0);
    if (!use_b) chk("post_done_addr", 64'(ad), 64'd31);
  endtask

  task automatic rand_rf();
    for (int i = 0; i < 32; i++) rf[i] = $urandom();
  endtask

  initial begin
    int dc;
    reset = 1'b0;
    start_a = 0; abort_a = 0; ready_a = 0;
    start_b = 0; abort_b = 0; ready_b = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    #1;
    chk("rst_busy",  64'(busy_a),  64'd0);
    chk("rst_done",  64'(done_a),  64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_char",  64'(char_a),  64'd0);
    chk("rst_addr",  64'(addr_a),  64'd0);
    chk("rst_b_busy", 64'(busy_b), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_check("idle0");

    // abort beats start in IDLE
    @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); start_a = 1'b0; abort_a = 1'b0; #1;
    chk("abort_start_busy", 64'(busy_a), 64'd0);

    // T1: r1 pattern, sink always ready
    rf[1] = 32'h1234ABCD;
    snap = rf;
    build_exp(0, 31, 1'b1, 8'h0A);
    run_dump(1'b0, 100, 0, 0, 0, 1'b0, dc);
    chk("t1_done_cycle", 64'(dc), 64'd321);
    cmp_stream("t1");

    // T2: same content, ready ~30%
    run_dump(1'b0, 30, 0, 0, 0, 1'b0, dc);
    cmp_stream("t2");

    // randomized content and backpressure
    for (int k = 0; k < 3; k++) begin
      rand_rf();
      snap = rf;
      build_exp(0, 31, 1'b1, 8'h0A);
      run_dump(1'b0, $urandom_range(100, 20), 0, 0, 0, 1'b0, dc);
      cmp_stream($sformatf("rnd%0d", k));
    end

    // T6: write to r2 just before its capture edge is seen, a later write is not
    rand_rf();
    rf[2] = 32'd0;
    snap = rf;
    snap[2] = 32'h0000FFFF;
    build_exp(0, 31, 1'b1, 8'h0A);
    run_dump(1'b0, 100, 21, 0, 0, 1'b0, dc);
    chk("t6_done_cycle", 64'(dc), 64'd321);
    cmp_stream("t6");

    // T3: abort on r5 nibble 3, then a fresh dump from FIRST_REG
    rand_rf();
    snap = rf;
    build_exp(0, 31, 1'b1, 8'h0A);
    run_dump(1'b0, 100, 0, 55, 0, 1'b0, dc);
    idle_check("t3_idle");
    run_dump(1'b0, 100, 0, 0, 0, 1'b0, dc);
    chk("t3_restart_done", 64'(dc), 64'd321);
    cmp_stream("t3_restart");

    // T4: async reset mid-EMIT
    run_dump(1'b0, 100, 0, 0, 137, 1'b0, dc);
    idle_check("t4_idle_a");
    idle_check("t4_idle_b");
    run_dump(1'b0, 60, 0, 0, 0, 1'b0, dc);
    cmp_stream("t4_after");

    // T5: single lowercase register, stray start pulses throughout
    rf[3] = 32'hDEADBEEF;
    snap = rf;
    build_exp(3, 3, 1'b0, 8'h0A);
    run_dump(1'b1, 100, 0, 0, 0, 1'b1, dc);
    chk("t5_done_cycle", 64'(dc), 64'd11);
    cmp_stream("t5");
    run_dump(1'b1, 50, 0, 0, 0, 1'b1, dc);
    cmp_stream("t5_bp");
    chk("t5_a_idle", 64'(busy_a), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
